a429_tx: RTL
============

# a429_tx

ARINC 429 word transmitter. Accepts 32-bit words over a valid/ready handshake, serialises them LSB-first as bipolar return-to-zero onto the HI/LO line-driver enables, and inserts a fixed null gap between words. Sits in the ARINC 429 subsystem as the transmit-side counterpart of the receive path, between the CPU-facing TX FIFO and the external line driver.

## Interface

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency
- GAP_BITS, 4, null bit-times inserted after every word (1..15)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- speed_hi  in  1  1 = 100 kbit/s, 0 = 12.5 kbit/s; sampled at word acceptance
- tx_data  in  32  word to send; tx_data[0] is transmitted first (ARINC bit 1)
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  block can accept a word
- tx_busy  out  1  word or gap in progress
- tx_done  out  1  one-cycle pulse when the last data bit completes
- line_a  out  1  HI driver enable
- line_b  out  1  LO driver enable

## Operation

- Half-bit period H = CLK_FREQ_HZ / (2 × rate): 250 cycles at 100 kbit/s and 2000 cycles at 12.5 kbit/s with default clock. Integer division; the remainder is dropped.
- States:
  - IDLE: tx_ready=1, lines null. tx_valid&tx_ready → latch tx_data and speed_hi, bit index=0, go to BIT_DRV.
  - BIT_DRV: lasts H cycles. Bit=1 → line_a=1, line_b=0. Bit=0 → line_a=0, line_b=1. Then go to BIT_RZ.
  - BIT_RZ: lasts H cycles, both lines 0. Index<31 → index+1, go to BIT_DRV. Index=31 → pulse tx_done, go to GAP.
  - GAP: lasts GAP_BITS×2H cycles with lines null, then go to IDLE.
- line_a and line_b are never 1 at the same time, including across reset and state changes.
- tx_data, tx_valid and speed_hi are ignored outside IDLE. A speed change mid-word has no effect.
- tx_busy = !tx_ready.
- Outputs are registered. Reset values: tx_ready=1, tx_busy=0, tx_done=0, line_a=0, line_b=0.
- Reset asserted mid-word or mid-gap: lines go null immediately (asynchronous). The word is discarded with no tx_done, and the block returns to IDLE.

## Timing

- Acceptance happens at clock edge k. line_a/line_b show bit 0 from edge k+1.
- Bit n drive phase starts at edge k+1+2nH.
- tx_done is high for the single cycle following edge k+64H.
- tx_ready returns high at edge k+1+(32+GAP_BITS)×2H. A word can be accepted on that same cycle, so back-to-back words have exactly GAP_BITS of null between them.
- Half-bit counter: 16 bits. It reloads on every state entry and counts down to 1.

## Configuration

- A429_TX_PARITY_EN
  - Defined: transmitted bit 31 is odd parity over the latched tx_data[30:0]. tx_data[31] is ignored.
  - Undefined: bit 31 is sent as supplied.

## Structure

- Package a429_pkg holds:
  - the state enum (IDLE, BIT_DRV, BIT_RZ, GAP)
  - RATE_HI_BPS=100_000 and RATE_LO_BPS=12_500
  - the half-period width constant (16)
- Sub-module a429_baud_gen: loadable half-bit down-counter. Inputs: load, speed select, multiplier (1 or 2×GAP_BITS). Output: expiry tick. The FSM, shift register and parity logic stay in a429_tx.

## Test plan

- 50 MHz, speed_hi=1, tx_data=0x0000_0001 accepted at edge k → line_a high for 250 cycles from k+1, then line_b pulses for bits 1..31, and tx_ready returns at k+18001.
- speed_hi=0, tx_data=0xFFFF_FFFF (parity macro undefined) → 32 line_a pulses, each 2000 cycles high and 2000 low, with line_b always 0. tx_done pulses once, after edge k+128000.
- A429_TX_PARITY_EN defined, tx_data=0x0000_0003 → bit 31 sent as 1 (two ones, so odd parity adds 1). tx_data=0x8000_0001 → bit 31 sent as 0.
- tx_valid held high with two words queued → second word's bit 0 starts exactly 2000 cycles (4 null bits at 100 kbit/s) after the first word's bit 31 RZ ends.
- rst_n pulsed low during bit 10 → lines 0 within the same cycle, no tx_done, and tx_ready=1 after release.
- speed_hi toggled mid-word → every remaining bit keeps its 250-cycle half-period.

Source files
------------

// File: rtl/a429_pkg.sv
// Shared types and constants for the ARINC 429 transmit path.
package a429_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BIT_DRV,
        BIT_RZ,
        GAP
    } a429_state_e;

    localparam int RATE_HI_BPS = 100_000;
    localparam int RATE_LO_BPS = 12_500;
    localparam int HALF_W      = 16;

endpackage

// File: rtl/a429_baud_gen.sv
// Loadable half-bit down-counter; tick_o is high in the last cycle of a loaded period.
module a429_baud_gen
    import a429_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       speed_hi_i,
    input  logic [4:0] mult_i,
    output logic       tick_o
);

    localparam int HALF_HI = CLK_FREQ_HZ / (2 * RATE_HI_BPS);
    localparam int HALF_LO = CLK_FREQ_HZ / (2 * RATE_LO_BPS);

    logic [HALF_W-1:0] cnt_q;
    logic [HALF_W-1:0] cnt_d;
    logic [HALF_W-1:0] halfBase;
    logic [HALF_W-1:0] loadVal;

    assign halfBase = speed_hi_i ? HALF_W'(HALF_HI) : HALF_W'(HALF_LO);
    assign loadVal  = halfBase * {11'd0, mult_i};
    assign tick_o   = (cnt_q == 16'd1);

    // Counts down to 1 and parks there until the next load.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = loadVal;
        end else if (cnt_q > 16'd1) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/a429_tx.sv
// ARINC 429 word transmitter: LSB-first bipolar RZ with a fixed null gap after each word.
// Build option A429_TX_PARITY_EN: bit 31 is replaced by odd parity over bits 30:0.
module a429_tx
    import a429_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int GAP_BITS    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        speed_hi,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        line_a,
    output logic        line_b
);

    localparam logic [4:0] GAP_MULT = 5'(2 * GAP_BITS);

    a429_state_e state_q;
    logic [31:0] shift_q;
    logic [4:0]  idx_q;
    logic        speed_q;
    logic        ready_q;
    logic        done_q;
    logic        lineA_q;
    logic        lineB_q;

    logic [31:0] word_d;
    logic        accept;
    logic        tick;
    logic        loadBaud;
    logic        speedSel;
    logic [4:0]  mult;

    always_comb begin
`ifdef A429_TX_PARITY_EN
        word_d = {~^tx_data[30:0], tx_data[30:0]};
`else
        word_d = tx_data;
`endif
    end

    assign accept   = tx_valid && ready_q;
    assign loadBaud = accept || ((state_q != IDLE) && tick);
    assign mult     = ((state_q == BIT_RZ) && (idx_q == 5'd31)) ? GAP_MULT : 5'd1;
    // The rate is taken live only at acceptance; afterwards the latched copy rules.
    assign speedSel = (state_q == IDLE) ? speed_hi : speed_q;

    a429_baud_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (loadBaud),
        .speed_hi_i(speedSel),
        .mult_i    (mult),
        .tick_o    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            speed_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            lineA_q <= 1'b0;
            lineB_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q <= word_d;
                        speed_q <= speed_hi;
                        idx_q   <= '0;
                        lineA_q <= word_d[0];
                        lineB_q <= ~word_d[0];
                        ready_q <= 1'b0;
                        state_q <= BIT_DRV;
                    end
                end
                BIT_DRV: begin
                    if (tick) begin
                        lineA_q <= 1'b0;
                        lineB_q <= 1'b0;
                        shift_q <= {1'b0, shift_q[31:1]};
                        state_q <= BIT_RZ;
                    end
                end
                BIT_RZ: begin
                    if (tick) begin
                        if (idx_q == 5'd31) begin
                            done_q  <= 1'b1;
                            state_q <= GAP;
                        end else begin
                            idx_q   <= idx_q + 5'd1;
                            lineA_q <= shift_q[0];
                            lineB_q <= ~shift_q[0];
                            state_q <= BIT_DRV;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready = ready_q;
    assign tx_busy  = ~ready_q;
    assign tx_done  = done_q;
    assign line_a   = lineA_q;
    assign line_b   = lineB_q;

endmodule
